mod_arbiter: RTL and testbench
==============================

Name: mod_arbiter

Overview:
- Shares one iterative modulo datapath (repeated-subtract unit with start/done control) between NREQ requesters.
- Round-robin arbitration; each operation is started, waited on and returned with a requester ID.
- b = 0 operands are trapped locally and never issued to the datapath.
- Sits between the processor's multi-cycle execute requesters and the single modulo unit.

Parameters:
- WIDTH, 32, operand/result width in bits.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must equal ceil(log2(NREQ)).
- TIMEOUT, 1024, watchdog limit in cycles (used only with MOD_ARB_TIMEOUT_EN).

Ports:
- CLK  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot grant/accept.
- req_a  in  NREQ*WIDTH  dividends; requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  divisors, same packing.
- mod_start  out  1  one-cycle start pulse to the datapath.
- mod_a  out  WIDTH  latched dividend to the datapath.
- mod_b  out  WIDTH  latched divisor to the datapath.
- mod_done  in  1  datapath completion pulse.
- mod_result  in  WIDTH  datapath remainder; valid when mod_done = 1.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester being answered.
- rsp_result  out  WIDTH  remainder.
- rsp_err  out  1  1 = divide-by-zero or timeout.

Behaviour:
- Clock and reset: single clock CLK; reset is synchronous and active-high.
- On reset:
  - state = IDLE; rr_ptr = NREQ-1, so requester 0 wins first.
  - All outputs 0: req_ready, mod_start, mod_a, mod_b, rsp_valid, rsp_id, rsp_result, rsp_err.
- States: IDLE, ISSUE, WAIT, RESP (2-bit encoding).
- IDLE:
  - winner g = first i with req_valid[i], searching (rr_ptr+1) mod NREQ upward with wrap.
  - req_ready = one-hot(g), combinational, asserted only in IDLE.
  - Handshake fires the same cycle; latch a_r, b_r and gid = g.
  - If b = 0: go to RESP with rsp_result = a, rsp_err = 1; the datapath is not touched.
  - Otherwise go to ISSUE.
  - No req_valid: stay in IDLE.
- ISSUE:
  - mod_start = 1 for exactly this cycle; mod_a = a_r, mod_b = b_r.
  - mod_a/mod_b hold through ISSUE and WAIT.
  - Next state WAIT.
- WAIT:
  - On mod_done: latch mod_result into rsp_result, rsp_err = 0, go to RESP.
  - Otherwise hold.
- RESP:
  - rsp_valid = 1; rsp_id = gid; rsp_result and rsp_err stable until accepted.
  - On rsp_ready: rr_ptr = gid, rsp_valid drops next cycle, go to IDLE.
  - Without rsp_ready: hold all response outputs unchanged.
- Latency, normal path:
  - Accept at cycle t; mod_start at t+1.
  - rsp_valid at the cycle after mod_done is sampled.
  - Best case rsp_valid at t+3 (mod_done at t+2).
- Latency, b = 0 path: rsp_valid at t+1.
- Throughput: one operation in flight. The next accept comes at earliest the cycle after the rsp handshake; IDLE must be entered first.
- Fairness: a requester holding req_valid is granted within NREQ operations.
- Simultaneous events:
  - mod_done in IDLE, ISSUE or RESP is ignored.
  - A requester that drops req_valid before grant loses nothing; there is no latching before the handshake.
- Reset mid-operation: abandon the operation, no response is produced, return to IDLE and the reset values above.
  - The datapath is expected to be reset by the same reset.
- Arithmetic: no arithmetic in this block beyond the b = 0 compare and the pointer wrap, (rr_ptr+1) mod NREQ.

Optional Feature:
- MOD_ARB_TIMEOUT_EN defined:
  - Add a cycle counter, cleared on entry to WAIT and incremented each WAIT cycle.
  - If the counter reaches TIMEOUT with no mod_done: go to RESP with rsp_result = 0, rsp_err = 1.
  - A mod_done in the same cycle as the timeout takes priority: normal result, err = 0.
  - Late mod_done is ignored.
- Not defined: no counter; WAIT waits indefinitely; TIMEOUT is unused.

Test Plan:
- Reset, then req_valid = 0001, a = 17, b = 5:
  - req_ready = 0001 at t; mod_start pulse at t+1 with mod_a = 17, mod_b = 5.
  - Model returns done with result 2 → rsp_valid, rsp_id = 0, rsp_result = 2, rsp_err = 0.
- Requester 2, a = 9, b = 0 → req_ready = 0100; no mod_start ever; rsp_valid at t+1 with rsp_result = 9, rsp_err = 1.
- req_valid = 1111 held, four operations → grants in order 0, 1, 2, 3, then 0 again; each rsp_id matches its grant.
- Hold rsp_ready = 0 for 5 cycles in RESP → rsp_* stable, no req_ready asserted; rsp_ready = 1 → IDLE next cycle.
- Assert reset during WAIT → next cycle all outputs 0 and state IDLE; a later mod_done produces no response.
- With MOD_ARB_TIMEOUT_EN, TIMEOUT = 8, mod_done never arrives → rsp_err = 1, rsp_result = 0, entered 8 cycles after WAIT entry.

Source files
------------

// File: rtl/mod_arbiter_if.sv
// Requester, datapath and response signals shared by mod_arbiter and its neighbours.
// slave = arbiter side, master = requesters / modulo unit / response consumer side.
interface mod_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  mod_start;
    logic [WIDTH-1:0]      mod_a;
    logic [WIDTH-1:0]      mod_b;
    logic                  mod_done;
    logic [WIDTH-1:0]      mod_result;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_result;
    logic                  rsp_err;

    modport slave (
        input  req_valid, req_a, req_b, mod_done, mod_result, rsp_ready,
        output req_ready, mod_start, mod_a, mod_b, rsp_valid, rsp_id, rsp_result, rsp_err
    );

    modport master (
        output req_valid, req_a, req_b, mod_done, mod_result, rsp_ready,
        input  req_ready, mod_start, mod_a, mod_b, rsp_valid, rsp_id, rsp_result, rsp_err
    );
endinterface

// File: rtl/mod_arbiter.sv
// Round-robin arbiter sharing one iterative modulo unit among NREQ requesters; b = 0 is trapped locally.
// Define MOD_ARB_TIMEOUT_EN to add a watchdog that ends a WAIT after TIMEOUT cycles with rsp_err = 1.
module mod_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 1024
) (
    input logic          CLK,
    input logic          reset,
    mod_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   rr_ptr, gid, win;
    logic             win_vld;
    logic [NREQ-1:0]  grant, req_rdy;
    logic [WIDTH-1:0] a_sel, b_sel, a_r, b_r, res_r;
    logic             err_r, tmo, start, rsp_vld;

    if (NREQ < 2 || NREQ > 8 || IDW != $clog2(NREQ) || TIMEOUT < 1) begin : g_param_check
        $error("mod_arbiter: illegal parameter combination");
    end

    // Search starts one past the last served requester and wraps at NREQ.
    always_comb begin
        logic [IDW:0]   sum;
        logic [IDW-1:0] idx;
        sum     = '0;
        idx     = '0;
        win     = '0;
        win_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr} + (IDW+1)'(k + 1);
            if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
            idx = sum[IDW-1:0];
            if (!win_vld && bus.req_valid[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                a_sel    = bus.req_a[i*WIDTH +: WIDTH];
                b_sel    = bus.req_b[i*WIDTH +: WIDTH];
                grant[i] = win_vld;
            end
        end
    end

`ifdef MOD_ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);
    logic [CNTW-1:0] wait_cnt;

    always_ff @(posedge CLK) begin
        if (reset || state != WAIT) wait_cnt <= '0;
        else                        wait_cnt <= wait_cnt + CNTW'(1);
    end

    assign tmo = (state == WAIT) && (wait_cnt == CNTW'(TIMEOUT - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_rdy   = '0;
        start     = 1'b0;
        rsp_vld   = 1'b0;
        case (state)
            IDLE: begin
                req_rdy = grant;
                if (win_vld) state_nxt = (b_sel == '0) ? RESP : ISSUE;
            end
            ISSUE: begin
                start     = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.mod_done || tmo) state_nxt = RESP;
            end
            RESP: begin
                rsp_vld = 1'b1;
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand/response capture; mod_done wins over a simultaneous timeout.
    always_ff @(posedge CLK) begin
        if (reset) begin
            rr_ptr <= IDW'(NREQ - 1);
            gid    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            res_r  <= '0;
            err_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (win_vld) begin
                    gid <= win;
                    if (b_sel == '0) begin
                        res_r <= a_sel;
                        err_r <= 1'b1;
                    end else begin
                        a_r <= a_sel;
                        b_r <= b_sel;
                    end
                end
                WAIT: if (bus.mod_done) begin
                    res_r <= bus.mod_result;
                    err_r <= 1'b0;
                end else if (tmo) begin
                    res_r <= '0;
                    err_r <= 1'b1;
                end
                RESP: if (bus.rsp_ready) rr_ptr <= gid;
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = req_rdy & {NREQ{~reset}};
    assign bus.mod_start  = start;
    assign bus.mod_a      = a_r;
    assign bus.mod_b      = b_r;
    assign bus.rsp_valid  = rsp_vld;
    assign bus.rsp_id     = gid;
    assign bus.rsp_result = res_r;
    assign bus.rsp_err    = err_r;
endmodule

// File: tb/tb_mod_arbiter.sv
// Scoreboard bench for mod_arbiter with a behavioural modulo datapath of programmable latency.
// The watchdog scenario is included when MOD_ARB_TIMEOUT_EN is defined (TIMEOUT = 8).
module tb_mod_arbiter;
    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] res;
        logic        err;
    } rsp_t;

    logic CLK;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    rsp_t sb[$];

    int          dp_lat  = 1;
    int          dp_cnt  = 0;
    int          n_start = 0;
    logic [31:0] dp_a, dp_b;

    mod_arbiter_if #(.WIDTH(32), .NREQ(4), .IDW(2)) bus ();

    mod_arbiter #(.WIDTH(32), .NREQ(4), .IDW(2), .TIMEOUT(8)) dut (
        .CLK  (CLK),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Datapath model: done pulse dp_lat cycles after the start pulse; dp_lat = 0 never answers.
    initial begin
        bus.mod_done   = 1'b0;
        bus.mod_result = '0;
        forever begin
            @(posedge CLK);
            #1;
            bus.mod_done = 1'b0;
            if (dp_cnt > 0) begin
                dp_cnt--;
                if (dp_cnt == 0) begin
                    bus.mod_done   = 1'b1;
                    bus.mod_result = dp_a % dp_b;
                end
            end
            if (bus.mod_start === 1'b1) begin
                n_start++;
                dp_a   = bus.mod_a;
                dp_b   = bus.mod_b;
                dp_cnt = dp_lat;
            end
        end
    end

    // Response monitor: every accepted response must match the oldest expectation.
    initial begin
        rsp_t got, exp_r;
        forever begin
            @(posedge CLK);
            #3;
            if (reset === 1'b0 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
                got = {bus.rsp_id, bus.rsp_result, bus.rsp_err};
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected got=%0h want=none", got);
                end else begin
                    exp_r = sb.pop_front();
                    if (got !== exp_r) begin
                        errors++;
                        $display("FAIL rsp_scoreboard got id=%0d res=%0d err=%0b want id=%0d res=%0d err=%0b",
                                 got.id, got.res, got.err, exp_r.id, exp_r.res, exp_r.err);
                    end
                end
            end
        end
    end

    function automatic rsp_t mk(input int id, input logic [31:0] res, input logic err);
        rsp_t r;
        r.id  = 2'(id);
        r.res = res;
        r.err = err;
        return r;
    endfunction

    task automatic to_drive();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) to_drive();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_req_ready got=%0h want=0", bus.req_ready);
        end
        checks++;
        if (bus.mod_start !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_pulses got start=%0b valid=%0b want 0 0", bus.mod_start, bus.rsp_valid);
        end
        checks++;
        if (bus.mod_a !== 32'd0 || bus.mod_b !== 32'd0) begin
            errors++; $display("FAIL reset_mod_ab got a=%0h b=%0h want 0 0", bus.mod_a, bus.mod_b);
        end
        checks++;
        if (bus.rsp_id !== 2'd0 || bus.rsp_result !== 32'd0 || bus.rsp_err !== 1'b0) begin
            errors++; $display("FAIL reset_rsp got id=%0d res=%0h err=%0b want 0 0 0", bus.rsp_id, bus.rsp_result, bus.rsp_err);
        end
    endtask

    task automatic test_basic();
        int n;
        to_drive();
        set_req(0, 32'd17, 32'd5);
        bus.req_valid = 4'b0001;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++; $display("FAIL basic_grant got=%0b want=0001", bus.req_ready);
        end
        sb.push_back(mk(0, 32'd2, 1'b0));
        to_drive();
        bus.req_valid = '0;
        #1;
        checks++;
        if (bus.mod_start !== 1'b1 || bus.mod_a !== 32'd17 || bus.mod_b !== 32'd5) begin
            errors++; $display("FAIL basic_issue got start=%0b a=%0d b=%0d want 1 17 5", bus.mod_start, bus.mod_a, bus.mod_b);
        end
        n = 1;
        while (bus.rsp_valid !== 1'b1 && n < 50) begin
            to_drive(); #1; n++;
        end
        checks++;
        if (n != 3) begin
            errors++; $display("FAIL basic_latency got=%0d want=3", n);
        end
        checks++;
        if (bus.rsp_id !== 2'd0 || bus.rsp_result !== 32'd2 || bus.rsp_err !== 1'b0) begin
            errors++; $display("FAIL basic_rsp got id=%0d res=%0d err=%0b want 0 2 0", bus.rsp_id, bus.rsp_result, bus.rsp_err);
        end
        to_drive();
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL basic_rsp_drop got=%0b want=0", bus.rsp_valid);
        end
    endtask

    task automatic test_div_zero();
        int starts0;
        starts0 = n_start;
        to_drive();
        set_req(2, 32'd9, 32'd0);
        bus.req_valid = 4'b0100;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            errors++; $display("FAIL dz_grant got=%0b want=0100", bus.req_ready);
        end
        sb.push_back(mk(2, 32'd9, 1'b1));
        to_drive();
        bus.req_valid = '0;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'd9 || bus.rsp_err !== 1'b1) begin
            errors++; $display("FAIL dz_rsp got valid=%0b res=%0d err=%0b want 1 9 1", bus.rsp_valid, bus.rsp_result, bus.rsp_err);
        end
        repeat (3) to_drive();
        checks++;
        if (n_start != starts0) begin
            errors++; $display("FAIL dz_no_start got=%0d want=%0d", n_start, starts0);
        end
    endtask

    task automatic test_round_robin();
        int n, exp_id;
        logic [3:0] exp_g;
        reset = 1'b1;
        to_drive();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 32'(20 + 7 * i), 32'(3 + i));
        bus.req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (bus.req_ready === 4'b0000 && n < 20) begin
                to_drive(); #1; n++;
            end
            exp_id = k % 4;
            exp_g  = 4'b0001 << exp_id;
            checks++;
            if (bus.req_ready !== exp_g) begin
                errors++; $display("FAIL rr_grant%0d got=%0b want=%0b", k, bus.req_ready, exp_g);
            end
            sb.push_back(mk(exp_id, 32'((20 + 7 * exp_id) % (3 + exp_id)), 1'b0));
            to_drive();
            #1;
        end
        bus.req_valid = '0;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            to_drive(); #1; n++;
        end
        to_drive();
    endtask

    task automatic test_back_to_back();
        int n;
        bus.rsp_ready = 1'b0;
        set_req(1, 32'd100, 32'd7);
        bus.req_valid = 4'b0010;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_grant got=%0b want=0010", bus.req_ready);
        end
        sb.push_back(mk(1, 32'd2, 1'b0));
        to_drive();
        bus.req_valid = 4'b1111;
        #1;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            to_drive(); #1; n++;
        end
        for (int k = 0; k < 5; k++) begin
            to_drive();
            #1;
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_result !== 32'd2 ||
                bus.rsp_err !== 1'b0 || bus.req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold%0d got valid=%0b id=%0d res=%0d err=%0b rdy=%0b want 1 1 2 0 0000",
                         k, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_err, bus.req_ready);
            end
        end
        to_drive();
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        to_drive();
        set_req(0, 32'd17, 32'd5);
        bus.req_valid = 4'b0001;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0001) begin
            errors++; $display("FAIL bp_idle got valid=%0b rdy=%0b want 0 0001", bus.rsp_valid, bus.req_ready);
        end
        sb.push_back(mk(0, 32'd2, 1'b0));
        to_drive();
        bus.req_valid = '0;
        #1;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            to_drive(); #1; n++;
        end
        to_drive();
    endtask

    task automatic test_reset_wait();
        logic seen;
        dp_lat = 6;
        to_drive();
        set_req(3, 32'd50, 32'd8);
        bus.req_valid = 4'b1000;
        #1;
        checks++;
        if (bus.req_ready !== 4'b1000) begin
            errors++; $display("FAIL rw_grant got=%0b want=1000", bus.req_ready);
        end
        to_drive();
        bus.req_valid = '0;
        #1;
        checks++;
        if (bus.mod_start !== 1'b1 || bus.mod_a !== 32'd50) begin
            errors++; $display("FAIL rw_issue got start=%0b a=%0d want 1 50", bus.mod_start, bus.mod_a);
        end
        to_drive();
        reset = 1'b1;
        to_drive();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.mod_start !== 1'b0 || bus.req_ready !== 4'b0000 ||
            bus.mod_a !== 32'd0 || bus.mod_b !== 32'd0 || bus.rsp_id !== 2'd0 ||
            bus.rsp_result !== 32'd0 || bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL rw_outputs got valid=%0b start=%0b rdy=%0b a=%0d b=%0d id=%0d res=%0d err=%0b want all 0",
                     bus.rsp_valid, bus.mod_start, bus.req_ready, bus.mod_a, bus.mod_b,
                     bus.rsp_id, bus.rsp_result, bus.rsp_err);
        end
        seen = 1'b0;
        repeat (12) begin
            to_drive();
            #1;
            if (bus.rsp_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL rw_late_done got rsp_valid=1 want=0");
        end
        dp_lat = 1;
    endtask

`ifdef MOD_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        dp_lat = 0;
        to_drive();
        set_req(1, 32'd33, 32'd4);
        bus.req_valid = 4'b0010;
        #1;
        sb.push_back(mk(1, 32'd0, 1'b1));
        to_drive();
        bus.req_valid = '0;
        #1;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin
            to_drive(); #1; n++;
        end
        checks++;
        if (n != 9) begin
            errors++; $display("FAIL to_latency got=%0d want=9", n);
        end
        checks++;
        if (bus.rsp_result !== 32'd0 || bus.rsp_err !== 1'b1) begin
            errors++; $display("FAIL to_rsp got res=%0d err=%0b want 0 1", bus.rsp_result, bus.rsp_err);
        end
        to_drive();
        dp_lat = 1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_round_robin();
        test_back_to_back();
        test_reset_wait();
`ifdef MOD_ARB_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) to_drive();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_drained got=%0d want=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
